// File: rtl/timer_cnt_cmp_if.sv
// Interface bundling the timer counter/compare control inputs and status outputs.
// The master modport drives it (divider/halt control and software); the slave is the counter block.
interface timer_cnt_cmp_if #(
    parameter int CNT_W = 64
);
    logic             cnt_en;
    logic             halt_ack;
    logic             wr_en;
    logic [1:0]       wr_sel;
    logic [31:0]      wdata;
    logic             int_en;
    logic             int_clr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cmp;
    logic             int_st;
    logic             tim_int;
    logic             wrap;
    logic             halted;

    modport master (
        output cnt_en, halt_ack, wr_en, wr_sel, wdata, int_en, int_clr,
        input  cnt, cmp, int_st, tim_int, wrap, halted
    );

    modport slave (
        input  cnt_en, halt_ack, wr_en, wr_sel, wdata, int_en, int_clr,
        output cnt, cmp, int_st, tim_int, wrap, halted
    );
endinterface

// File: rtl/timer_cnt_cmp.sv
// Free-running main counter with compare register, sticky match status and interrupt line.
// Counter and compare are software-writable in 32-bit halves; counting only on cnt_en.
module timer_cnt_cmp #(
    parameter int               CNT_W   = 64,
    parameter logic [CNT_W-1:0] CMP_RST = {CNT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_cnt_cmp_if.slave   bus
);
    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             int_st_q, int_st_d;
    logic             wrap_q, wrap_d;
    logic             halted_q, halted_d;
    logic             match;

    // Software writes to the counter pre-empt the increment for that cycle.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.wr_en && bus.wr_sel == 2'd0) begin
            cnt_d[31:0] = bus.wdata;
        end else if (bus.wr_en && bus.wr_sel == 2'd1) begin
            cnt_d[CNT_W-1:32] = bus.wdata[HI_W-1:0];
        end else if (bus.cnt_en) begin
            cnt_d  = cnt_q + CNT_W'(1);
            wrap_d = &cnt_q;
        end
    end

    always_comb begin
        cmp_d = cmp_q;
        if (bus.wr_en && bus.wr_sel == 2'd2) begin
            cmp_d[31:0] = bus.wdata;
        end else if (bus.wr_en && bus.wr_sel == 2'd3) begin
            cmp_d[CNT_W-1:32] = bus.wdata[HI_W-1:0];
        end
    end

    // Level-based match on pre-edge values; a live match overrides a clear request.
    assign match = (cnt_q == cmp_q);

    always_comb begin
        int_st_d = int_st_q;
        if (match) begin
            int_st_d = 1'b1;
        end else if (bus.int_clr) begin
            int_st_d = 1'b0;
        end
    end

    assign halted_d = bus.halt_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cmp_q    <= CMP_RST;
            int_st_q <= 1'b0;
            wrap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            int_st_q <= int_st_d;
            wrap_q   <= wrap_d;
            halted_q <= halted_d;
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.cmp     = cmp_q;
    assign bus.int_st  = int_st_q;
    assign bus.tim_int = int_st_q & bus.int_en;
    assign bus.wrap    = wrap_q;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_timer_cnt_cmp.sv
// Directed bench for timer_cnt_cmp: the driver pushes expected snapshots into a queue,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_timer_cnt_cmp;
    localparam int W     = 64;
    localparam int EXP_W = 2 * W + 4;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic clk;
    logic rst_n;

    timer_cnt_cmp_if #(.CNT_W(W)) bus ();

    timer_cnt_cmp #(.CNT_W(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares one expected snapshot per falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            string            n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            cmp_field(n, "cnt", bus.cnt, e[EXP_W-1 -: W]);
            cmp_field(n, "cmp", bus.cmp, e[EXP_W-1-W -: W]);
            cmp_field(n, "int_st", W'(bus.int_st), W'(e[3]));
            cmp_field(n, "tim_int", W'(bus.tim_int), W'(e[2]));
            cmp_field(n, "wrap", W'(bus.wrap), W'(e[1]));
            cmp_field(n, "halted", W'(bus.halted), W'(e[0]));
        end
    end

    task automatic cmp_field(input string n, input string f,
                             input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h expected=0x%0h", n, f, act, exp);
        end
    endtask

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [W-1:0] c, input logic [W-1:0] m,
                       input logic st, input logic ti, input logic wr, input logic h);
        exp_q.push_back({c, m, st, ti, wr, h});
        name_q.push_back(n);
        @(negedge clk);
        #1;
    endtask

    task automatic sw_write(input logic [1:0] sel, input logic [31:0] d);
        bus.wr_en  = 1'b1;
        bus.wr_sel = sel;
        bus.wdata  = d;
        cyc();
        bus.wr_en  = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.cnt_en   = 1'b0;
        bus.halt_ack = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 2'd0;
        bus.wdata    = 32'd0;
        bus.int_en   = 1'b0;
        bus.int_clr  = 1'b0;

        #12;
        chk("reset", 64'd0, ONES, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Free run for 5 increments
        bus.cnt_en = 1'b1;
        repeat (5) cyc();
        bus.cnt_en = 1'b0;
        chk("run5", 64'd5, ONES, 1'b0, 1'b0, 1'b0, 1'b0);

        // Compare = 3, count up from 0, match then clear
        sw_write(2'd2, 32'd3);
        sw_write(2'd3, 32'd0);
        sw_write(2'd0, 32'd0);
        bus.int_en = 1'b1;
        chk("cmp_load", 64'd0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.cnt_en = 1'b1;
        repeat (3) cyc();
        chk("cnt_eq3", 64'd3, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("match_set", 64'd4, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.cnt_en  = 1'b0;
        bus.int_clr = 1'b1;
        cyc();
        bus.int_clr = 1'b0;
        chk("int_clr", 64'd4, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full roll-over
        sw_write(2'd0, 32'hFFFF_FFFF);
        sw_write(2'd1, 32'hFFFF_FFFF);
        chk("no_wrap_on_write", ONES, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.cnt_en = 1'b1;
        cyc();
        bus.cnt_en = 1'b0;
        chk("wrap_pulse", 64'd0, 64'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("wrap_gone", 64'd0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Carry from low to high half
        sw_write(2'd0, 32'hFFFF_FFFF);
        sw_write(2'd1, 32'd0);
        bus.cnt_en = 1'b1;
        cyc();
        bus.cnt_en = 1'b0;
        chk("carry", 64'h1_0000_0000, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write beats increment in the same cycle
        bus.cnt_en = 1'b1;
        sw_write(2'd0, 32'h10);
        chk("wr_over_inc", 64'h1_0000_0010, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.cnt_en = 1'b0;
        chk("inc_after_wr", 64'h1_0000_0011, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Held match: set beats clear; int_en gates only the line
        sw_write(2'd0, 32'd3);
        sw_write(2'd1, 32'd0);
        bus.int_clr = 1'b1;
        cyc();
        bus.int_clr = 1'b0;
        chk("set_beats_clr", 64'd3, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.int_en = 1'b0;
        chk("int_en_off", 64'd3, 64'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("sticky", 64'd3, 64'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Debug halt: frozen counter, writes still accepted
        bus.halt_ack = 1'b1;
        cyc();
        chk("halt_1", 64'd3, 64'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (8) cyc();
        sw_write(2'd2, 32'h20);
        chk("halt_10", 64'd3, 64'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.halt_ack = 1'b0;
        cyc();
        chk("unhalt", 64'd3, 64'h20, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of counting
        bus.cnt_en = 1'b1;
        repeat (3) cyc();
        bus.halt_ack = 1'b1;
        cyc();
        chk("pre_reset", 64'd7, 64'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'd0, ONES, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.halt_ack = 1'b0;
        rst_n = 1'b1;
        cyc();
        bus.cnt_en = 1'b0;
        chk("resume", 64'd1, ONES, 1'b0, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
